// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the dmem_responder block:
//   - size_e     : access size encoding (1, 2, 4 or 8 bytes)
//   - state_e    : responder FSM states
//   - LATENCY_*  : legal bounds of the LATENCY parameter
//   - CNT_W      : width of the wait-state down-counter
//   - helpers turning a size into a byte mask / low-address mask
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,  // 1 byte
        SIZE_H = 2'd1,  // 2 bytes
        SIZE_W = 2'd2,  // 4 bytes
        SIZE_D = 2'd3   // 8 bytes
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    localparam int CNT_W       = 3;  // holds LATENCY_MAX-2

    // Bytes touched by an access of the given size, starting at lane 0.
    function automatic logic [7:0] size_byte_mask(input size_e size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_addr_mask(input size_e size);
        case (size)
            SIZE_B:  return 3'b000;
            SIZE_H:  return 3'b001;
            SIZE_W:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between an initiator (master) and dmem_responder
// (slave).
//   req_valid/req_ready   : request handshake
//   req_addr [63:0]       : byte address
//   req_wen               : 1 = store, 0 = load
//   req_size [1:0]        : 0=1B, 1=2B, 2=4B, 3=8B
//   req_wdata[63:0]       : store data, right-aligned
//   resp_valid/resp_ready : response handshake
//   resp_rdata[63:0]      : load data, right-aligned, zero-extended
//   resp_err              : access fault
// -----------------------------------------------------------------------------
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane.sv
// -----------------------------------------------------------------------------
// dmem_lane
// Byte-lane steering for one 64-bit array word.
//   word_i   : current contents of the addressed word
//   wdata_i  : right-aligned store data (bytes above the size are ignored)
//   size_i   : access size
//   lane_i   : byte offset of the access within the word
//   merged_o : word_i with the enabled bytes replaced by the shifted store data
//   rdata_o  : word_i shifted down by lane_i bytes, bytes above size zeroed
// -----------------------------------------------------------------------------
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    input  size_e       size_i,
    input  logic [2:0]  lane_i,
    output logic [63:0] merged_o,
    output logic [63:0] rdata_o
);

    logic [7:0]  size_mask;
    logic [7:0]  byte_en;
    logic [63:0] wdata_sh;
    logic [63:0] word_sh;

    // NOTE: combinational blocks use blocking '=' so each statement sees the
    // value computed just above it, and every output is assigned on every
    // pass so no latch can be inferred.
    always_comb begin
        size_mask = size_byte_mask(size_i);
        byte_en   = size_mask << lane_i;
        wdata_sh  = wdata_i << {lane_i, 3'b000};
        word_sh   = word_i >> {lane_i, 3'b000};
        for (int b = 0; b < 8; b++) begin
            merged_o[8*b +: 8] = byte_en[b]   ? wdata_sh[8*b +: 8] : word_i[8*b +: 8];
            rdata_o[8*b +: 8]  = size_mask[b] ? word_sh[8*b +: 8]  : 8'h00;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Fixed-latency data-memory responder backed by a DEPTH_WORDS x 64-bit array.
// One access is in flight at a time: IDLE accepts, WAIT counts down, RESP holds
// the response until the initiator takes it.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset (array contents are kept)
//   bus  : dmem_responder_if.slave request/response bus
// Parameters: BASE_ADDR (byte address of word 0), DEPTH_WORDS, LATENCY (1..7).
// Build option: DMEM_ALIGN_CHECK_EN -- when defined, an access whose address is
// not a multiple of its size faults; otherwise the low address bits are cleared.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int                IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0]       LIMIT_BYTES = 64'(DEPTH_WORDS) << 3;
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(LATENCY - 2);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range 1..7");
    end

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       addr_q;
    logic [63:0]       wdata_q;
    logic              wen_q;
    size_e             size_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [63:0]       resp_rdata_q;

    logic [63:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              commit;
    logic [63:0]       acc_addr;
    logic [63:0]       acc_wdata;
    logic              acc_wen;
    size_e             acc_size;
    logic [63:0]       offset;
    logic              in_range;
    logic              misaligned;
    logic              fault;
    logic [2:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic [63:0]       word_rd;
    logic [63:0]       merged;
    logic [63:0]       lane_rdata;
    logic              mem_we;
    logic [63:0]       resp_rdata_d;
    logic              resp_err_d;

    // The access being committed comes straight from the bus when LATENCY=1
    // (commit on the accept edge), otherwise from the latched request.
    always_comb begin
        accept = bus.req_valid && req_ready_q;
        commit = (state_q == ST_IDLE && accept && LATENCY == 1) ||
                 (state_q == ST_WAIT && cnt_q == '0);

        if (state_q == ST_IDLE) begin
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wen   = bus.req_wen;
            acc_size  = size_e'(bus.req_size);
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wen   = wen_q;
            acc_size  = size_q;
        end

        offset   = acc_addr - BASE_ADDR;
        in_range = (acc_addr >= BASE_ADDR) && (offset < LIMIT_BYTES);
        idx      = IDX_W'(offset >> 3);
`ifdef DMEM_ALIGN_CHECK_EN
        misaligned = |(acc_addr[2:0] & size_addr_mask(acc_size));
        lane       = acc_addr[2:0];
`else
        misaligned = 1'b0;
        lane       = acc_addr[2:0] & ~size_addr_mask(acc_size);
`endif
        fault   = !in_range || misaligned;
        word_rd = mem[idx];

        // A reset on the commit edge discards the pending store.
        mem_we       = commit && acc_wen && !fault && !rst;
        resp_err_d   = fault;
        resp_rdata_d = (fault || acc_wen) ? '0 : lane_rdata;
    end

    dmem_lane u_lane (
        .word_i   (word_rd),
        .wdata_i  (acc_wdata),
        .size_i   (acc_size),
        .lane_i   (lane),
        .merged_o (merged),
        .rdata_o  (lane_rdata)
    );

    // NOTE: the array has no reset; it keeps its contents across rst and
    // carries no reset network, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wen_q       <= bus.req_wen;
                        size_q      <= size_e'(bus.req_size);
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Back to IDLE only; ready rises a cycle later, so no
                    // request can be taken on the handshake edge.
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= resp_rdata_d;
                resp_err_q   <= resp_err_d;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Two instances: LATENCY=2 (main function,
// ranges, stalls, lanes) and LATENCY=3 (reset while a store is pending).
// Expected values are hand-computed constants. Honours DMEM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst2;
    logic rst3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus3 ();

    dmem_responder #(.LATENCY(2)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.slave)
    );

    dmem_responder #(.LATENCY(3)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus2.req_ready : bus3.req_ready;
    endfunction

    function automatic logic rvalid(input int d);
        return (d == 0) ? bus2.resp_valid : bus3.resp_valid;
    endfunction

    function automatic logic [63:0] rdat(input int d);
        return (d == 0) ? bus2.resp_rdata : bus3.resp_rdata;
    endfunction

    function automatic logic rerr(input int d);
        return (d == 0) ? bus2.resp_err : bus3.resp_err;
    endfunction

    task automatic set_req(input int d, input logic v, input logic wen, input logic [1:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata);
        if (d == 0) begin
            bus2.req_valid = v; bus2.req_wen = wen; bus2.req_size = size;
            bus2.req_addr = addr; bus2.req_wdata = wdata;
        end else begin
            bus3.req_valid = v; bus3.req_wen = wen; bus3.req_size = size;
            bus3.req_addr = addr; bus3.req_wdata = wdata;
        end
    endtask

    task automatic set_rready(input int d, input logic r);
        if (d == 0) bus2.resp_ready = r;
        else        bus3.resp_ready = r;
    endtask

    // One complete access. Inputs change and outputs are sampled on negedges.
    // stall: cycles resp_ready is held low once resp_valid is up.
    // eager: resp_ready is raised together with the request.
    task automatic access(input string tag, input int d, input logic wen, input logic [1:0] size,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int stall, input logic eager);
        int guard;
        int lat;
        logic [63:0] rd;
        logic er;
        @(negedge clk);
        set_req(d, 1'b1, wen, size, addr, wdata);
        set_rready(d, eager);
        guard = 0;
        while (!rdy(d) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy(d)) begin
            check({tag, "_accept_timeout"}, 64'(rdy(d)), 64'd1);
            set_req(d, 1'b0, 1'b0, 2'd0, '0, '0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        set_req(d, 1'b0, 1'b0, 2'd0, '0, '0);
        lat = 1;
        while (!rvalid(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_resp_valid"}, 64'(rvalid(d)), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        rd = rdat(d);
        er = rerr(d);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 64'(er), 64'(exp_err));
        check({tag, "_ready_in_resp"}, 64'(rdy(d)), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 64'(rvalid(d)), 64'd1);
            check({tag, "_stall_rdata"}, rdat(d), rd);
            check({tag, "_stall_err"}, 64'(rerr(d)), 64'(er));
            check({tag, "_stall_ready"}, 64'(rdy(d)), 64'd0);
        end
        set_rready(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rready(d, 1'b0);
        check({tag, "_idle_ready"}, 64'(rdy(d)), 64'd1);
        check({tag, "_valid_drop"}, 64'(rvalid(d)), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst2 = 1'b1;
        rst3 = 1'b1;
        set_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
        set_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
        set_rready(0, 1'b0);
        set_rready(1, 1'b0);
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        rst3 = 1'b0;

        check("rst_resp_valid", 64'(bus2.resp_valid), 64'd0);
        check("rst_resp_rdata", bus2.resp_rdata, 64'd0);
        check("rst_resp_err", 64'(bus2.resp_err), 64'd0);
        check("rst_req_ready", 64'(bus2.req_ready), 64'd1);

        // Doubleword store then load back.
        access("st_d",  0, 1'b1, 2'd3, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 2, 0, 1'b0);
        access("ld_d",  0, 1'b0, 2'd3, 64'h8000_0010, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 2, 0, 1'b0);

        // Byte at 0x13 is lane 3 of the word at 0x10.
        access("st_b13", 0, 1'b1, 2'd0, 64'h8000_0013, 64'hAB, 64'h0, 1'b0, 2, 0, 1'b0);
        access("ld_w13", 0, 1'b0, 2'd2, 64'h8000_0010, 64'h0, 64'h0000_0000_AB66_7788, 1'b0, 2, 0, 1'b0);

        // Restore the word, then put the byte in lane 2.
        access("st_d2",  0, 1'b1, 2'd3, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 2, 0, 1'b0);
        access("st_b12", 0, 1'b1, 2'd0, 64'h8000_0012, 64'hAB, 64'h0, 1'b0, 2, 0, 1'b0);
        access("ld_w12", 0, 1'b0, 2'd2, 64'h8000_0010, 64'h0, 64'h0000_0000_55AB_7788, 1'b0, 2, 0, 1'b0);

        // Response held for 5 cycles.
        access("stall",  0, 1'b0, 2'd3, 64'h8000_0010, 64'h0, 64'h1122_3344_55AB_7788, 1'b0, 2, 5, 1'b0);

        // Sub-word loads from upper lanes.
        access("ld_h16", 0, 1'b0, 2'd1, 64'h8000_0016, 64'h0, 64'h1122, 1'b0, 2, 0, 1'b0);
        access("ld_b14", 0, 1'b0, 2'd0, 64'h8000_0014, 64'h0, 64'h44, 1'b0, 2, 0, 1'b0);

        // Halfword store with junk upper data, resp_ready high from the start.
        access("st_h14", 0, 1'b1, 2'd1, 64'h8000_0014, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0, 1'b0, 2, 0, 1'b1);
        access("ld_dh",  0, 1'b0, 2'd3, 64'h8000_0010, 64'h0, 64'h1122_BEEF_55AB_7788, 1'b0, 2, 0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        access("misalign", 0, 1'b0, 2'd1, 64'h8000_0011, 64'h0, 64'h0, 1'b1, 2, 0, 1'b0);
`else
        access("misalign", 0, 1'b0, 2'd1, 64'h8000_0011, 64'h0, 64'h7788, 1'b0, 2, 0, 1'b0);
`endif

        // Range faults; out-of-range stores would alias onto the first and
        // last words if the write were not suppressed.
        access("pre_lo", 0, 1'b1, 2'd3, 64'h8000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0, 2, 0, 1'b0);
        access("pre_hi", 0, 1'b1, 2'd3, 64'h8000_1FF8, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b0, 2, 0, 1'b0);
        access("ld_below", 0, 1'b0, 2'd3, 64'h7FFF_FFF8, 64'h0, 64'h0, 1'b1, 2, 0, 1'b0);
        access("ld_above", 0, 1'b0, 2'd3, 64'h8000_2000, 64'h0, 64'h0, 1'b1, 2, 0, 1'b0);
        access("st_above", 0, 1'b1, 2'd3, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2, 0, 1'b0);
        access("st_below", 0, 1'b1, 2'd3, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2, 0, 1'b0);
        access("chk_lo", 0, 1'b0, 2'd3, 64'h8000_0000, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 2, 0, 1'b0);
        access("chk_hi", 0, 1'b0, 2'd3, 64'h8000_1FF8, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 2, 0, 1'b0);

        // LATENCY=3: reset one cycle after a store is accepted.
        access("l3_st", 1, 1'b1, 2'd3, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 3, 0, 1'b0);
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 2'd3, 64'h8000_0010, 64'hDEAD_BEEF_DEAD_BEEF);
        check("l3_rst_pre_ready", 64'(bus3.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | bus3.resp_valid;
            @(negedge clk);
        end
        check("l3_rst_no_resp", 64'(seen), 64'd0);
        check("l3_rst_ready", 64'(bus3.req_ready), 64'd1);
        access("l3_ld", 1, 1'b0, 2'd3, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
